// File: rtl/edge_event_arbiter.sv
// Edge capture on N_CH asynchronous lines, round-robin hand-off onto one valid/ready port.
// Define EDGE_BOTH_EN to also capture falling edges and report their polarity on ev_pol.
module edge_event_arbiter #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         data_in,
  input  logic [N_CH-1:0]         en_mask,
  output logic                    ev_valid,
  input  logic                    ev_ready,
  output logic [$clog2(N_CH)-1:0] ev_id,
  output logic                    ev_pol,
  output logic [N_CH-1:0]         ev_drop,
  input  logic                    drop_clr
);
  localparam int unsigned IDW = $clog2(N_CH);

  typedef enum logic [0:0] {StIdle, StOffer} state_e;

  state_e          state_q, state_d;
  logic [N_CH-1:0] sync_q [SYNC_STAGES];
  logic [N_CH-1:0] s, s_d_q, edge_det, ack_vec, ovf;
  logic [N_CH-1:0] pending_q, pending_d, drop_q, drop_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d, id_q, id_d, pick, cand;
  logic [31:0]     idx;
  logic            found, ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(SYNC_STAGES); k++) sync_q[k] <= '0;
      s_d_q <= '0;
    end else begin
      sync_q[0] <= data_in;
      for (int k = 1; k < int'(SYNC_STAGES); k++) sync_q[k] <= sync_q[k-1];
      s_d_q <= s;
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef EDGE_BOTH_EN
  assign edge_det = en_mask & (s ^ s_d_q);
`else
  assign edge_det = en_mask & s & ~s_d_q;
`endif

  assign ack = (state_q == StOffer) && ev_ready;

  always_comb begin
    ack_vec = '0;
    if (ack) ack_vec[id_q] = 1'b1;
  end

  // A fresh edge on the channel being acked re-arms it instead of counting as overflow.
  assign ovf       = edge_det & pending_q & ~ack_vec;
  assign pending_d = (pending_q & ~ack_vec) | edge_det;
  assign drop_d    = (drop_clr ? '0 : drop_q) | ovf;

  // Round-robin scan starting one past the last served channel.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      idx  = (32'(rr_ptr_q) + k) % N_CH;
      cand = IDW'(idx);
      if (!found && pending_q[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StOffer;
          id_d    = pick;
        end
      end
      StOffer: begin
        if (ev_ready) begin
          state_d  = StIdle;
          rr_ptr_d = id_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pending_q <= '0;
      drop_q    <= '0;
      rr_ptr_q  <= '0;
      id_q      <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
      rr_ptr_q  <= rr_ptr_d;
      id_q      <= id_d;
    end
  end

`ifdef EDGE_BOTH_EN
  logic [N_CH-1:0] pol_q, pol_d, take;
  logic            pol_out_q;

  // Polarity is only recorded for edges that actually become pending.
  assign take  = edge_det & ~ovf;
  assign pol_d = (pol_q & ~take) | (s & take);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pol_q     <= '0;
      pol_out_q <= 1'b1;
    end else begin
      pol_q <= pol_d;
      if (state_q == StIdle && found) pol_out_q <= pol_q[pick];
    end
  end

  assign ev_pol = pol_out_q;
`else
  assign ev_pol = 1'b1;
`endif

  assign ev_valid = (state_q == StOffer);
  assign ev_id    = id_q;
  assign ev_drop  = drop_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Randomised and directed bench for edge_event_arbiter against a rule-level reference model.
module tb_edge_event_arbiter;
  localparam int N  = 4;
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] data_in = '0;
  logic [3:0] en_mask = 4'hF;
  logic       ev_valid, ev_pol;
  logic       ev_ready = 1'b1;
  logic       drop_clr = 1'b0;
  logic [1:0] ev_id;
  logic [3:0] ev_drop;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int evq[$];
  int polq[$];
  int cycq[$];

  edge_event_arbiter #(.N_CH(N), .SYNC_STAGES(SS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .en_mask  (en_mask),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_id    (ev_id),
    .ev_pol   (ev_pol),
    .ev_drop  (ev_drop),
    .drop_clr (drop_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: events are pending flags, arbitration is a circular scan.
  bit         m_valid;
  int         m_id;
  bit         m_pol;
  int         m_rr;
  bit         m_pend[N];
  bit         m_pp[N];
  bit   [3:0] m_drop;
  logic [3:0] m_hist[SS+1];

  task automatic model_reset();
    m_valid = 0; m_id = 0; m_pol = 1; m_rr = 0; m_drop = '0;
    for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_pp[i] = 0; end
    for (int k = 0; k <= SS; k++) m_hist[k] = '0;
  endtask

  task automatic model_step();
    bit hs, e, got;
    int hid, j;
    bit [3:0] s, sd, newdrop;
    hs = m_valid && ev_ready;
    hid = m_id;
    s = m_hist[SS-1];
    sd = m_hist[SS];
    if (!m_valid) begin
      got = 0;
      for (int k = 1; k <= N; k++) begin
        j = (m_rr + k) % N;
        if (!got && m_pend[j]) begin
          got = 1; m_valid = 1; m_id = j; m_pol = m_pp[j];
        end
      end
    end else if (hs) begin
      m_valid = 0;
      m_rr = hid;
    end
    newdrop = '0;
    for (int i = 0; i < N; i++) begin
`ifdef EDGE_BOTH_EN
      e = en_mask[i] && (s[i] != sd[i]);
`else
      e = en_mask[i] && s[i] && !sd[i];
`endif
      if (e) begin
        if (m_pend[i] && !(hs && hid == i)) newdrop[i] = 1;
        else begin m_pend[i] = 1; m_pp[i] = s[i]; end
      end else if (hs && hid == i) begin
        m_pend[i] = 0;
      end
    end
    m_drop = (drop_clr ? 4'b0 : m_drop) | newdrop;
    for (int k = SS; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = data_in;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model, plus a log of accepted events.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_valid", int'(ev_valid), 0);
      end else begin
        check("valid", int'(ev_valid), int'(m_valid));
        if (m_valid && ev_valid) begin
          check("id", int'(ev_id), m_id);
          check("pol", int'(ev_pol), int'(m_pol));
        end
        check("drop", int'(ev_drop), int'(m_drop));
        if (ev_valid && ev_ready) begin
          evq.push_back(int'(ev_id));
          polq.push_back(int'(ev_pol));
          cycq.push_back(cyc);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    tick(3);
    check("reset_valid", int'(ev_valid), 0);
    check("reset_id", int'(ev_id), 0);
    check("reset_pol", int'(ev_pol), 1);
    check("reset_drop", int'(ev_drop), 0);
    rst_n = 1'b1;
    tick(3);

    // Latency from first sampling edge to ev_valid.
    data_in[1] = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick(1);
      check("latency_valid", int'(ev_valid), int'(e == 4));
    end
    check("latency_id", int'(ev_id), 1);
    check("latency_pol", int'(ev_pol), 1);
    tick(1);
    check("single_pulse", int'(ev_valid), 0);
    data_in = '0;
    tick(12);

    // Serve ch3 so the scan restarts at ch0.
    data_in[3] = 1'b1;
    tick(3);
    data_in = '0;
    tick(12);

    for (int b = 0; b < 2; b++) begin
      evq.delete(); cycq.delete(); polq.delete();
      data_in = 4'hF;
      tick(20);
      check("burst_count", evq.size(), 4);
      for (int k = 0; k < 4; k++)
        check("burst_order", (k < evq.size()) ? evq[k] : -1, k);
      for (int k = 1; k < 4; k++)
        check("burst_spacing", (k < cycq.size()) ? cycq[k] - cycq[k-1] : -1, 2);
      data_in = '0;
      tick(20);
    end

    // Overflow while stalled, then clear.
    ev_ready = 1'b0;
    evq.delete();
    for (int p = 0; p < 2; p++) begin
      data_in[2] = 1'b1; tick(3);
      data_in[2] = 1'b0; tick(3);
    end
    tick(4);
    check("ovf_drop", int'(ev_drop), 4);
    check("ovf_valid", int'(ev_valid), 1);
    check("ovf_id", int'(ev_id), 2);
    ev_ready = 1'b1;
    tick(6);
    check("ovf_events", evq.size(), 1);
    check("ovf_event_id", (evq.size() > 0) ? evq[0] : -1, 2);
    drop_clr = 1'b1;
    tick(1);
    drop_clr = 1'b0;
    check("drop_clear", int'(ev_drop), 0);

    // Masked channel captures nothing; masking after capture still serves.
    evq.delete();
    en_mask = 4'b1110;
    data_in[0] = 1'b1; tick(8);
    data_in[0] = 1'b0; tick(8);
    check("mask_events", evq.size(), 0);
    check("mask_drop", int'(ev_drop), 0);
    en_mask = 4'hF;
    ev_ready = 1'b0;
    data_in[1] = 1'b1; tick(6);
    en_mask = 4'b1101;
    data_in[1] = 1'b0; tick(6);
    check("masked_pending_valid", int'(ev_valid), 1);
    check("masked_pending_id", int'(ev_id), 1);
    ev_ready = 1'b1;
    tick(4);
    check("masked_pending_served", evq.size(), 1);
    check("masked_pending_event", (evq.size() > 0) ? evq[0] : -1, 1);
    en_mask = 4'hF;
    tick(4);

    // Asynchronous reset while an event is offered.
    ev_ready = 1'b0;
    data_in[2] = 1'b1;
    tick(6);
    check("pre_reset_valid", int'(ev_valid), 1);
    #2;
    rst_n = 1'b0;
    data_in = '0;
    #1;
    check("async_reset_valid", int'(ev_valid), 0);
    tick(2);
    rst_n = 1'b1;
    ev_ready = 1'b1;
    evq.delete();
    tick(12);
    check("no_stale_event", evq.size(), 0);

    // Falling edge on ch3.
    data_in[3] = 1'b1;
    tick(10);
    evq.delete(); polq.delete();
    data_in[3] = 1'b0;
    tick(10);
`ifdef EDGE_BOTH_EN
    check("fall_events", evq.size(), 1);
    check("fall_id", (evq.size() > 0) ? evq[0] : -1, 3);
    check("fall_pol", (polq.size() > 0) ? polq[0] : -1, 0);
`else
    check("fall_events", evq.size(), 0);
`endif

    // Random traffic, checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      data_in = data_in ^ (4'($urandom) & 4'($urandom));
      if ($urandom_range(0, 7) == 0) en_mask = 4'($urandom);
      ev_ready = ($urandom_range(0, 2) != 0);
      drop_clr = ($urandom_range(0, 15) == 0);
      tick(1);
    end
    drop_clr = 1'b0;
    ev_ready = 1'b1;
    tick(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
